// File: rtl/cmos_frame_scheduler_if.sv
// Scheduler control/status bundle: camera vsyncs, writer handshake, channel select
// and per-channel configuration/status between the capture path and the scheduler.
interface cmos_frame_scheduler_if #(
   parameter int unsigned WEIGHT_W = 4,
   parameter int unsigned TO_W     = 24,
   parameter int unsigned CNT_W    = 16
);
   logic [1:0]          ch_enable;
   logic [WEIGHT_W-1:0] ch1_weight;
   logic [WEIGHT_W-1:0] ch2_weight;
   logic [TO_W-1:0]     timeout_cycles;
   logic                ch1_vsync;
   logic                ch2_vsync;
   logic                wr_ready;
   logic                sel_valid;
   logic                sel_ch;
   logic                frame_start;
   logic                frame_end;
   logic [1:0]          ch_timeout;
   logic [CNT_W-1:0]    frame_cnt1;
   logic [CNT_W-1:0]    frame_cnt2;

   modport master (
      output ch_enable, ch1_weight, ch2_weight, timeout_cycles,
      output ch1_vsync, ch2_vsync, wr_ready,
      input  sel_valid, sel_ch, frame_start, frame_end,
      input  ch_timeout, frame_cnt1, frame_cnt2
   );

   modport slave (
      input  ch_enable, ch1_weight, ch2_weight, timeout_cycles,
      input  ch1_vsync, ch2_vsync, wr_ready,
      output sel_valid, sel_ch, frame_start, frame_end,
      output ch_timeout, frame_cnt1, frame_cnt2
   );
endinterface

// File: rtl/cmos_frame_scheduler.sv
// Frame-granularity weighted round-robin scheduler for the two-camera capture path.
// Picks the owning channel per frame slot, gates on writer readiness and flags silent cameras.
module cmos_frame_scheduler #(
   parameter int unsigned WEIGHT_W = 4,
   parameter int unsigned TO_W     = 24,
   parameter int unsigned CNT_W    = 16
) (
   input logic                   cmos_pclk,
   input logic                   rst,
   cmos_frame_scheduler_if.slave sched
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PICK       = 2'd1;
   localparam logic [1:0] ST_WAIT_START = 2'd2;
   localparam logic [1:0] ST_PASS       = 2'd3;

   logic [1:0]          state_q, state_nxt;
   logic                sel_valid_q, sel_valid_nxt;
   logic                sel_ch_q, sel_ch_nxt;
   logic                frame_start_q, frame_start_nxt;
   logic                frame_end_q, frame_end_nxt;
   logic [1:0]          ch_timeout_q, ch_timeout_nxt;
   logic [CNT_W-1:0]    frame_cnt1_q, frame_cnt1_nxt;
   logic [CNT_W-1:0]    frame_cnt2_q, frame_cnt2_nxt;
   logic [WEIGHT_W-1:0] credit_q, credit_nxt;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_nxt;
   logic                first_pick_q, first_pick_nxt;
   logic                vsync1_d, vsync2_d;

   logic                ch1_fall, ch1_rise, ch2_fall, ch2_rise;
   logic                sel_fall, sel_rise;
   logic [WEIGHT_W-1:0] w1_eff, w2_eff, cur_w, oth_w;
   logic                cur_en, oth_en;

   // Same-cycle edge detect on the raw vsync against last cycle's value
   assign ch1_fall = !sched.ch1_vsync &&  vsync1_d;
   assign ch1_rise =  sched.ch1_vsync && !vsync1_d;
   assign ch2_fall = !sched.ch2_vsync &&  vsync2_d;
   assign ch2_rise =  sched.ch2_vsync && !vsync2_d;
   assign sel_fall = sel_ch_q ? ch2_fall : ch1_fall;
   assign sel_rise = sel_ch_q ? ch2_rise : ch1_rise;

   assign w1_eff = (sched.ch1_weight == '0) ? WEIGHT_W'(1) : sched.ch1_weight;
   assign w2_eff = (sched.ch2_weight == '0) ? WEIGHT_W'(1) : sched.ch2_weight;
   assign cur_w  = sel_ch_q ? w2_eff : w1_eff;
   assign oth_w  = sel_ch_q ? w1_eff : w2_eff;
   assign cur_en = sel_ch_q ? sched.ch_enable[1] : sched.ch_enable[0];
   assign oth_en = sel_ch_q ? sched.ch_enable[0] : sched.ch_enable[1];

   // Next-state and registered-output decode
   always_comb begin
      state_nxt       = state_q;
      sel_valid_nxt   = sel_valid_q;
      sel_ch_nxt      = sel_ch_q;
      frame_start_nxt = 1'b0;
      frame_end_nxt   = 1'b0;
      ch_timeout_nxt  = ch_timeout_q;
      frame_cnt1_nxt  = frame_cnt1_q;
      frame_cnt2_nxt  = frame_cnt2_q;
      credit_nxt      = credit_q;
      to_cnt_nxt      = to_cnt_q;
      first_pick_nxt  = first_pick_q;

      case (state_q)
         ST_IDLE: begin
            if (sched.ch_enable != 2'b00) state_nxt = ST_PICK;
         end

         ST_PICK: begin
            if (sched.ch_enable == 2'b00) begin
               state_nxt = ST_IDLE;
            end else if (sched.wr_ready) begin
               if (first_pick_q) begin
                  sel_ch_nxt     = !sched.ch_enable[0];
                  credit_nxt     = sched.ch_enable[0] ? w1_eff : w2_eff;
                  first_pick_nxt = 1'b0;
               end else if ((credit_q != '0) && cur_en) begin
                  sel_ch_nxt = sel_ch_q;
               end else if (oth_en) begin
                  sel_ch_nxt = !sel_ch_q;
                  credit_nxt = oth_w;
               end else begin
                  credit_nxt = cur_w;
               end
               to_cnt_nxt = '0;
               state_nxt  = ST_WAIT_START;
            end
         end

         ST_WAIT_START: begin
            if (sel_fall) begin
               sel_valid_nxt   = 1'b1;
               frame_start_nxt = 1'b1;
               state_nxt       = ST_PASS;
            end else begin
               to_cnt_nxt = to_cnt_q + TO_W'(1);
               // Silent camera: drop its remaining credit so the next pick rotates away
               if ((sched.timeout_cycles != '0) && (to_cnt_nxt == sched.timeout_cycles)) begin
                  ch_timeout_nxt[sel_ch_q] = 1'b1;
                  credit_nxt               = '0;
                  state_nxt                = ST_PICK;
               end
            end
         end

         ST_PASS: begin
            if (sel_rise) begin
               sel_valid_nxt            = 1'b0;
               frame_end_nxt            = 1'b1;
               ch_timeout_nxt[sel_ch_q] = 1'b0;
               if (credit_q != '0) credit_nxt = credit_q - WEIGHT_W'(1);
               if (sel_ch_q) frame_cnt2_nxt = frame_cnt2_q + CNT_W'(1);
               else          frame_cnt1_nxt = frame_cnt1_q + CNT_W'(1);
               state_nxt = ST_PICK;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge cmos_pclk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         sel_valid_q   <= 1'b0;
         sel_ch_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         ch_timeout_q  <= 2'b00;
         frame_cnt1_q  <= '0;
         frame_cnt2_q  <= '0;
         credit_q      <= '0;
         to_cnt_q      <= '0;
         first_pick_q  <= 1'b1;
         vsync1_d      <= 1'b0;
         vsync2_d      <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         sel_valid_q   <= sel_valid_nxt;
         sel_ch_q      <= sel_ch_nxt;
         frame_start_q <= frame_start_nxt;
         frame_end_q   <= frame_end_nxt;
         ch_timeout_q  <= ch_timeout_nxt;
         frame_cnt1_q  <= frame_cnt1_nxt;
         frame_cnt2_q  <= frame_cnt2_nxt;
         credit_q      <= credit_nxt;
         to_cnt_q      <= to_cnt_nxt;
         first_pick_q  <= first_pick_nxt;
         vsync1_d      <= sched.ch1_vsync;
         vsync2_d      <= sched.ch2_vsync;
      end
   end

   assign sched.sel_valid   = sel_valid_q;
   assign sched.sel_ch      = sel_ch_q;
   assign sched.frame_start = frame_start_q;
   assign sched.frame_end   = frame_end_q;
   assign sched.ch_timeout  = ch_timeout_q;
   assign sched.frame_cnt1  = frame_cnt1_q;
   assign sched.frame_cnt2  = frame_cnt2_q;

endmodule
